// File: rtl/mod_updown_counter.sv
// Synchronous up/down counter with a programmable terminal value. It supports
// wrap or saturate mode, a terminal-count flag and a registered wrap pulse.
module mod_updown_counter #(
  parameter int              WIDTH     = 4,
  parameter longint unsigned MAX_VALUE = (64'd1 << WIDTH) - 64'd1,
  parameter bit              SATURATE  = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             en,
  input  logic             up,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap
);

  generate
    if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
      $error("mod_updown_counter: WIDTH must be in 1..32");
    end
    if (MAX_VALUE < 64'd1 || MAX_VALUE > ((64'd1 << WIDTH) - 64'd1)) begin : g_bad_max
      $error("mod_updown_counter: MAX_VALUE must be in 1..2**WIDTH-1");
    end
  endgenerate

  localparam logic [WIDTH-1:0] MaxQ = MAX_VALUE[WIDTH-1:0];
  localparam logic [WIDTH-1:0] One  = WIDTH'(1);

  logic [WIDTH-1:0] r_q;
  logic             r_wrap;

  logic             w_atMax;
  logic             w_atZero;
  logic             w_tc;
  logic [WIDTH-1:0] w_loadClamped;
  logic [WIDTH-1:0] w_stepValue;

  assign w_atMax       = (r_q == MaxQ);
  assign w_atZero      = (r_q == '0);
  assign w_tc          = up ? w_atMax : w_atZero;
  assign w_loadClamped = (load_value > MaxQ) ? MaxQ : load_value;

  // Saturation holds the terminal value; wrap mode jumps to the opposite end.
  always_comb begin
    w_stepValue = r_q;
    if (up) begin
      if (w_atMax) begin
        w_stepValue = SATURATE ? MaxQ : '0;
      end else begin
        w_stepValue = r_q + One;
      end
    end else begin
      if (w_atZero) begin
        w_stepValue = SATURATE ? '0 : MaxQ;
      end else begin
        w_stepValue = r_q - One;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_q    <= '0;
      r_wrap <= 1'b0;
    end else if (clear) begin
      r_q    <= '0;
      r_wrap <= 1'b0;
    end else if (load) begin
      r_q    <= w_loadClamped;
      r_wrap <= 1'b0;
    end else if (en) begin
      r_q    <= w_stepValue;
      r_wrap <= w_tc;
    end else begin
      r_wrap <= 1'b0;
    end
  end

  assign q    = r_q;
  assign tc   = w_tc;
  assign wrap = r_wrap;

endmodule

// File: tb/tb_mod_updown_counter.sv
// Directed bench for mod_updown_counter: three instances cover wrap mode with
// MAX_VALUE=9, saturate mode with MAX_VALUE=9, and the full 4-bit range.
module tb_mod_updown_counter;

  logic clk;
  logic reset;

  logic       clearV [3];
  logic       loadV  [3];
  logic [3:0] lvV    [3];
  logic       enV    [3];
  logic       upV    [3];

  logic [3:0] q0, q1, q2;
  logic       tc0, tc1, tc2;
  logic       wrap0, wrap1, wrap2;

  int checks = 0;
  int passes = 0;

  mod_updown_counter #(.WIDTH(4), .MAX_VALUE(9), .SATURATE(1'b0)) u_wrap9 (
    .clk(clk), .reset(reset), .clear(clearV[0]), .load(loadV[0]),
    .load_value(lvV[0]), .en(enV[0]), .up(upV[0]),
    .q(q0), .tc(tc0), .wrap(wrap0)
  );

  mod_updown_counter #(.WIDTH(4), .MAX_VALUE(9), .SATURATE(1'b1)) u_sat9 (
    .clk(clk), .reset(reset), .clear(clearV[1]), .load(loadV[1]),
    .load_value(lvV[1]), .en(enV[1]), .up(upV[1]),
    .q(q1), .tc(tc1), .wrap(wrap1)
  );

  mod_updown_counter #(.WIDTH(4)) u_full16 (
    .clk(clk), .reset(reset), .clear(clearV[2]), .load(loadV[2]),
    .load_value(lvV[2]), .en(enV[2]), .up(upV[2]),
    .q(q2), .tc(tc2), .wrap(wrap2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drives one instance and leaves the other two idle (no clear, load or enable).
  task automatic applyStimulus(input int sel, input logic c, input logic l,
                               input logic [3:0] lv, input logic e, input logic u);
    for (int k = 0; k < 3; k++) begin
      clearV[k] = 1'b0;
      loadV[k]  = 1'b0;
      enV[k]    = 1'b0;
    end
    clearV[sel] = c;
    loadV[sel]  = l;
    lvV[sel]    = lv;
    enV[sel]    = e;
    upV[sel]    = u;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      clearV[k] = 1'b0;
      loadV[k]  = 1'b0;
      lvV[k]    = 4'd0;
      enV[k]    = 1'b0;
      upV[k]    = 1'b1;
    end

    #2;
    checkOutput("reset_q0", 32'(q0), 0);
    checkOutput("reset_wrap0", 32'(wrap0), 0);
    checkOutput("reset_q1", 32'(q1), 0);
    checkOutput("reset_q2", 32'(q2), 0);
    #10 reset = 1'b1;

    // Wrap up, MAX_VALUE=9: 1..9,0,1,2
    applyStimulus(0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
    for (int i = 1; i <= 12; i++) begin
      tick();
      checkOutput($sformatf("up_q_%0d", i), 32'(q0), i % 10);
      checkOutput($sformatf("up_tc_%0d", i), 32'(tc0), ((i % 10) == 9) ? 1 : 0);
      checkOutput($sformatf("up_wrap_%0d", i), 32'(wrap0), (i == 10) ? 1 : 0);
    end

    // Wrap down from 0
    applyStimulus(0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1);
    tick();
    checkOutput("clear_q", 32'(q0), 0);
    applyStimulus(0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
    #1;
    checkOutput("tc_down_at_zero", 32'(tc0), 1);
    tick();
    checkOutput("down_q_9", 32'(q0), 9);
    checkOutput("down_wrap_9", 32'(wrap0), 1);
    tick();
    checkOutput("down_q_8", 32'(q0), 8);
    checkOutput("down_wrap_8", 32'(wrap0), 0);
    tick();
    checkOutput("down_q_7", 32'(q0), 7);
    checkOutput("down_wrap_7", 32'(wrap0), 0);

    // Saturate: load 8, count up four times, then reverse
    applyStimulus(1, 1'b0, 1'b1, 4'd8, 1'b0, 1'b1);
    tick();
    checkOutput("sat_load_q", 32'(q1), 8);
    checkOutput("hold_q0_while_idle", 32'(q0), 7);
    applyStimulus(1, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
    tick();
    checkOutput("sat_q_1", 32'(q1), 9);
    checkOutput("sat_wrap_1", 32'(wrap1), 0);
    tick();
    checkOutput("sat_q_2", 32'(q1), 9);
    checkOutput("sat_wrap_2", 32'(wrap1), 1);
    tick();
    checkOutput("sat_q_3", 32'(q1), 9);
    checkOutput("sat_wrap_3", 32'(wrap1), 1);
    tick();
    checkOutput("sat_q_4", 32'(q1), 9);
    checkOutput("sat_wrap_4", 32'(wrap1), 1);
    applyStimulus(1, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
    tick();
    checkOutput("sat_rev_q", 32'(q1), 8);
    checkOutput("sat_rev_wrap", 32'(wrap1), 0);
    applyStimulus(1, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
    tick();
    tick();
    checkOutput("sat_again_q", 32'(q1), 9);
    checkOutput("sat_again_wrap", 32'(wrap1), 1);

    // Asynchronous reset between edges: q0 is 7 and wrap1 is pending high
    #3 reset = 1'b0;
    #1;
    checkOutput("async_q0", 32'(q0), 0);
    checkOutput("async_wrap0", 32'(wrap0), 0);
    checkOutput("async_q1", 32'(q1), 0);
    checkOutput("async_wrap1", 32'(wrap1), 0);
    #2 reset = 1'b1;
    applyStimulus(0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
    tick();
    checkOutput("post_reset_q0", 32'(q0), 1);

    // Priority and clamp
    applyStimulus(0, 1'b0, 1'b1, 4'd13, 1'b1, 1'b1);
    tick();
    checkOutput("clamp_q", 32'(q0), 9);
    checkOutput("clamp_wrap", 32'(wrap0), 0);
    applyStimulus(0, 1'b1, 1'b1, 4'd5, 1'b1, 1'b1);
    tick();
    checkOutput("clear_over_load_q", 32'(q0), 0);
    checkOutput("clear_over_load_wrap", 32'(wrap0), 0);
    applyStimulus(0, 1'b0, 1'b1, 4'd5, 1'b0, 1'b1);
    tick();
    checkOutput("load_in_range_q", 32'(q0), 5);

    // Full 4-bit range
    applyStimulus(2, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
    for (int i = 1; i <= 16; i++) begin
      tick();
      checkOutput($sformatf("full_q_%0d", i), 32'(q2), i % 16);
      checkOutput($sformatf("full_wrap_%0d", i), 32'(wrap2), (i == 16) ? 1 : 0);
    end
    applyStimulus(2, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
    for (int i = 1; i <= 3; i++) begin
      tick();
      checkOutput($sformatf("idle_q_%0d", i), 32'(q2), 0);
      checkOutput($sformatf("idle_wrap_%0d", i), 32'(wrap2), 0);
    end
    checkOutput("tc_full_up", 32'(tc2), 0);
    applyStimulus(2, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    #1;
    checkOutput("tc_full_down", 32'(tc2), 1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
